// File: rtl/axi_rd_slave_mem.sv
// AXI3 read-only memory slave. Accepts one AR burst at a time and streams
// FIXED/INCR/WRAP beats from a local word array, echoing the extended ID.
// A side-band preload port fills the array; the array itself is never reset.
module axi_rd_slave_mem #(
   parameter int unsigned            BUS_WIDTH  = 32,
   parameter int unsigned            ADDR_WIDTH = 32,
   parameter int unsigned            SID_WIDTH  = 5,
   parameter int unsigned            DEPTH      = 256,
   parameter logic [ADDR_WIDTH-1:0]  BASE_ADDR  = '0
) (
   input  logic                       clk,
   input  logic                       clr,
   input  logic [SID_WIDTH-1:0]       ARID,
   input  logic [ADDR_WIDTH-1:0]      ARADDR,
   input  logic [3:0]                 ARLEN,
   input  logic [2:0]                 ARSIZE,
   input  logic [1:0]                 ARBURST,
   input  logic                       ARVALID,
   output logic                       ARREADY,
   output logic [SID_WIDTH-1:0]       RID,
   output logic [BUS_WIDTH-1:0]       RDATA,
   output logic [3:0]                 RRESP,
   output logic                       RLAST,
   output logic                       RVALID,
   input  logic                       RREADY,
   input  logic                       pre_we,
   input  logic [$clog2(DEPTH)-1:0]   pre_idx,
   input  logic [BUS_WIDTH-1:0]       pre_wdata
);

   localparam int unsigned LSB  = $clog2(BUS_WIDTH / 8);
   localparam int unsigned IDXW = $clog2(DEPTH);

   typedef enum logic [0:0] {StIdle, StBeat} state_e;

   state_e                  state_q, state_d;
   logic                    arready_q, arready_d;
   logic                    rvalid_q, rvalid_d;
   logic                    rlast_q, rlast_d;
   logic [SID_WIDTH-1:0]    rid_q, rid_d;
   logic [BUS_WIDTH-1:0]    rdata_q, rdata_d;
   logic [1:0]              rresp_q, rresp_d;
   logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
   logic [3:0]              len_q, len_d;
   logic [2:0]              size_q, size_d;
   logic [1:0]              burst_q, burst_d;
   logic [3:0]              beat_q, beat_d;
   logic                    berr_q, berr_d;

   logic [BUS_WIDTH-1:0]    mem [DEPTH];

   logic [ADDR_WIDTH-1:0]   step, span, next_addr;
   logic [ADDR_WIDTH-1:0]   rd_addr, rd_off, rd_word;
   logic                    rd_borrow, rd_berr, rd_load, rd_oob;
   logic [IDXW-1:0]         rd_idx;

   // Preload port; a same-edge beat load sees the pre-write contents.
   always_ff @(posedge clk) begin
      if (pre_we) begin
         mem[pre_idx] <= pre_wdata;
      end
   end

   // Address of the beat following the one currently presented.
   always_comb begin
      step = ADDR_WIDTH'(1) << size_q;
      span = (ADDR_WIDTH'(len_q) + ADDR_WIDTH'(1)) << size_q;
      unique case (burst_q)
         2'b00:   next_addr = addr_q;
         2'b10:   next_addr = (addr_q & ~(span - ADDR_WIDTH'(1))) |
                              ((addr_q + step) & (span - ADDR_WIDTH'(1)));
         default: next_addr = (addr_q & ~(step - ADDR_WIDTH'(1))) + step;
      endcase
   end

   // Next-state logic; every accepted AR or beat handshake registers the next R beat.
   always_comb begin
      state_d   = state_q;
      arready_d = arready_q;
      rvalid_d  = rvalid_q;
      rlast_d   = rlast_q;
      rid_d     = rid_q;
      rdata_d   = rdata_q;
      rresp_d   = rresp_q;
      addr_d    = addr_q;
      len_d     = len_q;
      size_d    = size_q;
      burst_d   = burst_q;
      beat_d    = beat_q;
      berr_d    = berr_q;
      rd_addr   = addr_q;
      rd_berr   = berr_q;
      rd_load   = 1'b0;

      unique case (state_q)
         StIdle: begin
            arready_d = 1'b1;
            if (ARVALID && arready_q) begin
               state_d   = StBeat;
               arready_d = 1'b0;
               rvalid_d  = 1'b1;
               rlast_d   = (ARLEN == 4'd0);
               rid_d     = ARID;
               addr_d    = ARADDR;
               len_d     = ARLEN;
               size_d    = ARSIZE;
               burst_d   = ARBURST;
               beat_d    = 4'd0;
               berr_d    = (ARBURST == 2'b11) || (ARSIZE > 3'(LSB)) ||
                           ((ARBURST == 2'b10) && !(ARLEN inside {4'd1, 4'd3, 4'd7, 4'd15}));
               rd_addr   = ARADDR;
               rd_berr   = berr_d;
               rd_load   = 1'b1;
            end
         end
         StBeat: begin
            if (rvalid_q && RREADY) begin
               if (beat_q == len_q) begin
                  state_d   = StIdle;
                  rvalid_d  = 1'b0;
                  rlast_d   = 1'b0;
                  arready_d = 1'b1;
               end else begin
                  beat_d  = beat_q + 4'd1;
                  rlast_d = ((beat_q + 4'd1) == len_q);
                  addr_d  = next_addr;
                  rd_addr = next_addr;
                  rd_load = 1'b1;
               end
            end
         end
         default: state_d = StIdle;
      endcase

      // Beat lookup: out-of-window addresses and bad bursts return zero data with SLVERR.
      {rd_borrow, rd_off} = {1'b0, rd_addr} - {1'b0, BASE_ADDR};
      rd_word = rd_off >> LSB;
      rd_idx  = rd_word[IDXW-1:0];
      rd_oob  = rd_borrow || (rd_word >= ADDR_WIDTH'(DEPTH));
      if (rd_load) begin
         if (rd_berr || rd_oob) begin
            rdata_d = '0;
            rresp_d = 2'b10;
         end else begin
            rdata_d = mem[rd_idx];
            rresp_d = 2'b00;
         end
      end
   end

   // State and registered R-channel outputs.
   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         state_q   <= StIdle;
         arready_q <= 1'b0;
         rvalid_q  <= 1'b0;
         rlast_q   <= 1'b0;
         rid_q     <= '0;
         rdata_q   <= '0;
         rresp_q   <= 2'b00;
         addr_q    <= '0;
         len_q     <= 4'd0;
         size_q    <= 3'd0;
         burst_q   <= 2'b00;
         beat_q    <= 4'd0;
         berr_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         arready_q <= arready_d;
         rvalid_q  <= rvalid_d;
         rlast_q   <= rlast_d;
         rid_q     <= rid_d;
         rdata_q   <= rdata_d;
         rresp_q   <= rresp_d;
         addr_q    <= addr_d;
         len_q     <= len_d;
         size_q    <= size_d;
         burst_q   <= burst_d;
         beat_q    <= beat_d;
         berr_q    <= berr_d;
      end
   end

   assign ARREADY = arready_q;
   assign RVALID  = rvalid_q;
   assign RLAST   = rlast_q;
   assign RID     = rid_q;
   assign RDATA   = rdata_q;
   assign RRESP   = {2'b00, rresp_q};

endmodule

// File: tb/tb_axi_rd_slave_mem.sv
// Self-checking bench for axi_rd_slave_mem: directed bursts plus randomized
// bursts, RREADY back-pressure and preloads, against a burst-level model.
module tb_axi_rd_slave_mem;

   localparam int unsigned BW    = 32;
   localparam int unsigned AW    = 32;
   localparam int unsigned SW    = 5;
   localparam int unsigned DEPTH = 256;
   localparam int unsigned IW    = 8;

   logic          clk = 1'b0;
   logic          clr = 1'b0;
   logic [SW-1:0] ARID = '0;
   logic [AW-1:0] ARADDR = '0;
   logic [3:0]    ARLEN = '0;
   logic [2:0]    ARSIZE = '0;
   logic [1:0]    ARBURST = '0;
   logic          ARVALID = 1'b0;
   logic          ARREADY;
   logic [SW-1:0] RID;
   logic [BW-1:0] RDATA;
   logic [3:0]    RRESP;
   logic          RLAST;
   logic          RVALID;
   logic          RREADY = 1'b0;
   logic          pre_we = 1'b0;
   logic [IW-1:0] pre_idx = '0;
   logic [BW-1:0] pre_wdata = '0;

   logic [BW-1:0] ref_mem [DEPTH];
   int unsigned   n_chk = 0;
   int unsigned   n_pass = 0;

   always #5 clk = ~clk;

   axi_rd_slave_mem #(
      .BUS_WIDTH  (BW),
      .ADDR_WIDTH (AW),
      .SID_WIDTH  (SW),
      .DEPTH      (DEPTH),
      .BASE_ADDR  ('0)
   ) dut (
      .clk       (clk),
      .clr       (clr),
      .ARID      (ARID),
      .ARADDR    (ARADDR),
      .ARLEN     (ARLEN),
      .ARSIZE    (ARSIZE),
      .ARBURST   (ARBURST),
      .ARVALID   (ARVALID),
      .ARREADY   (ARREADY),
      .RID       (RID),
      .RDATA     (RDATA),
      .RRESP     (RRESP),
      .RLAST     (RLAST),
      .RVALID    (RVALID),
      .RREADY    (RREADY),
      .pre_we    (pre_we),
      .pre_idx   (pre_idx),
      .pre_wdata (pre_wdata)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   // Byte address of beat k, straight from the burst definitions.
   function automatic logic [AW-1:0] beat_addr(input logic [AW-1:0] a, input int len,
                                               input int size, input int burst, input int k);
      longint unsigned step, span, base;
      step = longint'(1) << size;
      span = longint'(len + 1) * step;
      case (burst)
         0:       return a;
         2: begin
            base = (longint'(a) / span) * span;
            return AW'(base + ((longint'(a) + longint'(k) * step) % span));
         end
         default: return (k == 0) ? a : AW'((longint'(a) / step) * step + longint'(k) * step);
      endcase
   endfunction

   function automatic logic burst_bad(input int len, input int size, input int burst);
      return (burst == 3) || (size > 2) ||
             (burst == 2 && !(len == 1 || len == 3 || len == 7 || len == 15));
   endfunction

   task automatic model_beat(input logic [AW-1:0] a, input logic bad,
                             output logic [BW-1:0] d, output logic [3:0] r);
      logic [AW-1:0] word;
      word = a >> 2;
      if (bad || word >= AW'(DEPTH)) begin
         d = '0;
         r = 4'h2;
      end else begin
         d = ref_mem[word[IW-1:0]];
         r = 4'h0;
      end
   endtask

   task automatic preload(input int idx, input logic [BW-1:0] d);
      pre_we    = 1'b1;
      pre_idx   = IW'(idx);
      pre_wdata = d;
      @(negedge clk);
      pre_we = 1'b0;
      ref_mem[idx] = d;
   endtask

   // mode 0: RREADY always 1; mode 1: random RREADY and preloads; mode 2: RREADY from pat.
   task automatic run_burst(input logic [SW-1:0] id, input logic [AW-1:0] a, input int len,
                            input int size, input int burst, input int mode,
                            input logic [15:0] pat);
      logic          bad, r;
      logic [BW-1:0] ed, nd;
      logic [3:0]    er, nr;
      logic [AW-1:0] cur;
      int            k, cyc, waited;
      waited = 0;
      while (!ARREADY && waited < 20) begin
         @(negedge clk);
         waited++;
      end
      if (!ARREADY) begin
         check("arready_wait", 64'(ARREADY), 64'd1);
         return;
      end
      bad = burst_bad(len, size, burst);
      model_beat(beat_addr(a, len, size, burst, 0), bad, ed, er);
      ARVALID = 1'b1;
      ARID    = id;
      ARADDR  = a;
      ARLEN   = 4'(len);
      ARSIZE  = 3'(size);
      ARBURST = 2'(burst);
      @(negedge clk);
      ARVALID = 1'b0;
      check("arready_drop", 64'(ARREADY), 64'd0);
      k   = 0;
      cyc = 0;
      nd  = '0;
      nr  = '0;
      while (k <= len && cyc < 300) begin
         check("rvalid", 64'(RVALID), 64'd1);
         check("rdata", 64'(RDATA), 64'(ed));
         check("rresp", 64'(RRESP), 64'(er));
         check("rlast", 64'(RLAST), 64'(k == len));
         check("rid", 64'(RID), 64'(id));
         case (mode)
            0:       r = 1'b1;
            1:       r = ($urandom_range(0, 2) != 0);
            default: r = (cyc < 16) ? pat[cyc] : 1'b1;
         endcase
         RREADY = r;
         if (mode == 1 && $urandom_range(0, 2) == 0) begin
            cur       = beat_addr(a, len, size, burst, k) >> 2;
            pre_we    = 1'b1;
            pre_idx   = $urandom_range(0, 1) ? cur[IW-1:0] : IW'($urandom);
            pre_wdata = $urandom;
         end
         // Next beat is captured from the array as it stood before this edge's preload.
         if (r && k < len) model_beat(beat_addr(a, len, size, burst, k + 1), bad, nd, nr);
         if (pre_we) ref_mem[pre_idx] = pre_wdata;
         @(negedge clk);
         pre_we = 1'b0;
         if (r) begin
            k++;
            ed = nd;
            er = nr;
         end
         cyc++;
      end
      if (k <= len) check("beat_timeout", 64'(k), 64'(len + 1));
      RREADY = 1'b0;
      check("end_rvalid", 64'(RVALID), 64'd0);
      check("end_rlast", 64'(RLAST), 64'd0);
      check("end_arready", 64'(ARREADY), 64'd1);
   endtask

   initial begin
      logic [31:0] a;
      int          len, size, burst;

      #1;
      check("rst_arready", 64'(ARREADY), 64'd0);
      check("rst_rvalid", 64'(RVALID), 64'd0);
      check("rst_rlast", 64'(RLAST), 64'd0);
      check("rst_rid", 64'(RID), 64'd0);
      check("rst_rdata", 64'(RDATA), 64'd0);
      check("rst_rresp", 64'(RRESP), 64'd0);
      @(negedge clk);
      @(negedge clk);
      clr = 1'b1;
      @(negedge clk);
      check("first_arready", 64'(ARREADY), 64'd1);

      for (int i = 0; i < int'(DEPTH); i++) preload(i, $urandom);
      for (int i = 0; i < 8; i++) preload(i, 32'h100 + 32'(i));

      // Directed bursts
      run_burst(5'h13, 32'h0, 3, 2, 1, 0, 16'h0);
      run_burst(5'h02, 32'h18, 3, 2, 2, 0, 16'h0);
      run_burst(5'h07, 32'h8, 2, 2, 0, 2, 16'b11001);
      run_burst(5'h1a, 32'h3f8, 3, 2, 1, 0, 16'h0);
      run_burst(5'h04, 32'h10, 1, 2, 3, 0, 16'h0);
      run_burst(5'h05, 32'h10, 1, 3, 1, 0, 16'h0);
      run_burst(5'h06, 32'h10, 2, 2, 2, 2, 16'b0101);
      run_burst(5'h08, 32'h1e, 7, 1, 2, 1, 16'h0);

      // Random bursts
      for (int n = 0; n < 60; n++) begin
         len   = $urandom_range(0, 15);
         size  = ($urandom_range(0, 9) == 0) ? 3 : $urandom_range(0, 2);
         burst = ($urandom_range(0, 9) == 0) ? 3 : $urandom_range(0, 2);
         a     = $urandom_range(0, 9) == 0 ? $urandom : 32'($urandom_range(0, 1100));
         run_burst(SW'($urandom), a, len, size, burst, 1, 16'h0);
      end

      // Reset during beat 2 of an 8-beat burst
      a = 32'h20;
      ARVALID = 1'b1;
      ARID    = 5'h11;
      ARADDR  = a;
      ARLEN   = 4'd7;
      ARSIZE  = 3'd2;
      ARBURST = 2'b01;
      RREADY  = 1'b1;
      @(negedge clk);
      ARVALID = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check("mid_beat2", 64'(RDATA), 64'(ref_mem[10]));
      clr = 1'b0;
      #1;
      check("mid_rvalid", 64'(RVALID), 64'd0);
      check("mid_arready", 64'(ARREADY), 64'd0);
      check("mid_rlast", 64'(RLAST), 64'd0);
      check("mid_rdata", 64'(RDATA), 64'd0);
      RREADY = 1'b0;
      @(negedge clk);
      @(negedge clk);
      clr = 1'b1;
      @(negedge clk);
      check("rel_arready", 64'(ARREADY), 64'd1);
      check("rel_rvalid", 64'(RVALID), 64'd0);
      run_burst(5'h09, 32'h14, 0, 2, 1, 0, 16'h0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/axi_rd_slave_mem.md
Name: axi_rd_slave_mem

Overview:
- AXI3 read-only memory slave; one instance hangs off each interconnect slave read port (S0_AR*/S0_R*, S1_AR*/S1_R*).
- Accepts one AR burst at a time and returns FIXED/INCR/WRAP read beats from a local word array.
- Echoes the extended ID produced by the interconnect.
- Side-band preload port lets the bench or boot logic fill the array.

Parameters:
- BUS_WIDTH, 32, data width in bits; power of two, >= 8.
- ADDR_WIDTH, 32, AXI address width.
- SID_WIDTH, 5, slave-side ID width (master ID_WIDTH 4 + $clog2(M) with M=2).
- DEPTH, 256, number of BUS_WIDTH words; power of two.
- BASE_ADDR, 0, byte address mapped to word 0.

Ports:
- clk  in  1  clock; all logic on posedge.
- clr  in  1  asynchronous active-low reset.
- ARID  in  SID_WIDTH  read address ID.
- ARADDR  in  ADDR_WIDTH  start byte address.
- ARLEN  in  4  beats minus one.
- ARSIZE  in  3  bytes per beat = 1<<ARSIZE.
- ARBURST  in  2  00 FIXED, 01 INCR, 10 WRAP, 11 reserved.
- ARVALID  in  1  address valid.
- ARREADY  out  1  address ready.
- RID  out  SID_WIDTH  latched ARID.
- RDATA  out  BUS_WIDTH  read data.
- RRESP  out  4  [1:0] 00 OKAY or 10 SLVERR; [3:2] always 0.
- RLAST  out  1  final beat.
- RVALID  out  1  data valid.
- RREADY  in  1  master ready.
- pre_we  in  1  preload write enable.
- pre_idx  in  $clog2(DEPTH)  preload word index.
- pre_wdata  in  BUS_WIDTH  preload data.

Behaviour:
- Reset (clr low, async): ARREADY=0, RVALID=0, RLAST=0, RID=0, RDATA=0, RRESP=0, FSM=IDLE. Memory array is not reset.
- First posedge after clr rises: ARREADY=1.
- FSM states:
  - IDLE (ARREADY=1): on ARVALID&ARREADY, latch id/addr/len/size/burst, clear beat counter, go to BEAT. ARREADY drops the next cycle.
  - BEAT (ARREADY=0, RVALID=1): the first beat is presented the cycle after the AR handshake (latency 1).
  - On RVALID&RREADY with beat<len: compute next address, register next RDATA/RRESP, beat+1. Back-to-back beats at one per cycle.
  - On RVALID&RREADY with beat==len: RVALID=0, RLAST=0, go to IDLE; ARREADY=1 that same edge (one idle cycle between bursts).
- R outputs are registers. RID/RDATA/RRESP/RLAST hold stable while RVALID=1 and RREADY=0. A preload to the word being presented does not alter the held RDATA.
- RLAST=1 exactly when beat==len; a len=0 burst has RLAST on its only beat.
- Word index = (addr - BASE_ADDR) >> $clog2(BUS_WIDTH/8).
- RDATA is always the full word; the master selects byte lanes for narrow sizes.
- Next-address rules:
  - FIXED: address unchanged.
  - INCR: next = (addr aligned down to size) + (1<<size). The unaligned first beat is honoured only for its word.
  - WRAP: span = (len+1)<<size; next = (addr & ~(span-1)) | ((addr + (1<<size)) & (span-1)).
- SLVERR cases; each beat has RRESP=10 and RDATA=0 but the full len+1 beats are still returned:
  - Whole burst: ARBURST=11; ARSIZE > $clog2(BUS_WIDTH/8); WRAP with len not in {1,3,7,15}.
  - Per beat: addr < BASE_ADDR, or word index >= DEPTH.
- Preload: on posedge with pre_we=1, mem[pre_idx] <= pre_wdata. A same-cycle read of that index, when the next beat is being registered, returns the old value.
- clr asserted mid-burst: outputs return to reset values immediately. The burst is abandoned with no further beats.

Test Plan:
- Preload mem[0..7]=0x100+i; AR addr 0x0, len 3, size 2, INCR, ARID 0x13, RREADY=1 -> RVALID the cycle after handshake; RDATA 0x100,0x101,0x102,0x103 on 4 consecutive cycles; RID 0x13; RLAST only on the 4th; RRESP 0; ARREADY back to 1 after the last beat.
- WRAP addr 0x18, len 3, size 2 -> RDATA 0x106,0x107,0x104,0x105.
- FIXED addr 0x8, len 2 -> RDATA 0x102 three times. Toggle RREADY 1,0,0,1,1 -> beats stall with RDATA, RLAST, RID stable.
- INCR addr 0x3F8, len 3, DEPTH 256 -> beats 0,1 OKAY; beats 2,3 RRESP=0x2 with RDATA 0; RLAST on beat 3.
- ARBURST=11 len 1 -> two beats with SLVERR. ARSIZE=3 on 32-bit bus -> all beats SLVERR.
- Pull clr low during beat 2 of a len=7 burst -> RVALID, ARREADY, RLAST go 0 immediately. After release, ARREADY=1 on the first edge and a new len=0 burst returns a single beat with RLAST=1.
